lu_issue_ctrl: RTL and testbench
================================

Name: lu_issue_ctrl

Overview:
- Multi-cycle sequencer that accepts R-type logic instructions and decodes them to the 4-bit logic-unit select.
- Reads both source operands from the register file, drives the 32-bit logic unit and writes the result back.
- It is the controlling end of the logic unit's operand/select/result interface: it produces A, B and sel, and it consumes out.
- Sits between instruction fetch and the register file in the R-type datapath.

Parameters:
- DW, 32, datapath width; must match the logic unit width.
- AW, 5, register address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  32  R-type instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  block can accept an instruction this cycle.
- ra1  output  AW  register file read address 1 (rs).
- ra2  output  AW  register file read address 2 (rt).
- rd1  input  DW  register file read data 1, combinational from ra1.
- rd2  input  DW  register file read data 2, combinational from ra2.
- lu_a  output  DW  logic unit operand A.
- lu_b  output  DW  logic unit operand B.
- lu_sel  output  4  logic unit select.
- lu_out  input  DW  logic unit result, combinational.
- wr_en  output  1  register file write strobe.
- wr_addr  output  AW  write address (rd).
- wr_data  output  DW  write data.
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse when an instruction is rejected.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All registered outputs are 0: ra1, ra2, lu_a, lu_b, lu_sel, wr_en, wr_addr, wr_data, done, illegal. instr_ready=1 only after reset is released.
- FSM states: IDLE, READ, EXEC, WB, ERR.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch rs/rt/rd and decode funct.
  - Legal instruction: opcode==6'h00 and funct in the decode map. Go to READ.
  - Anything else: go to ERR.
- READ:
  - ra1=rs, ra2=rt are registered and stable for the whole state.
  - At the end of the cycle, capture lu_a<=rd1, lu_b<=rd2 and lu_sel<=decoded sel. Go to EXEC.
- EXEC:
  - lu_a, lu_b and lu_sel are held stable.
  - At the end of the cycle, capture wr_data<=lu_out and wr_addr<=rd. Go to WB.
- WB:
  - wr_en=1 for exactly one cycle, unless rd==0, in which case wr_en=0 (r0 is hardwired).
  - done=1 in both cases.
  - Next state IDLE.
- ERR: illegal=1 for one cycle, no write, then IDLE.
- instr_ready is 0 in every state except IDLE. An instruction offered while busy is held by the producer, not dropped.
- Latency: acceptance edge at cycle 0; wr_en/done high in cycle 3. Throughput is one instruction per 4 cycles; an illegal instruction costs 2 cycles.
- lu_a, lu_b and lu_sel keep their last values outside EXEC; the logic unit output is sampled only in EXEC.
- Reset asserted mid-operation aborts immediately. No wr_en and no done are produced for the aborted instruction.
- Decode map (funct -> sel):
  - 0x24 AND -> 4'h0
  - 0x25 OR -> 4'h1
  - 0x26 XOR -> 4'h2
  - 0x27 NOR -> 4'h3
  - 0x28 NAND -> 4'h4
  - 0x29 XNOR -> 4'h5
  - 0x2A ANDN (A&~B) -> 4'h6
  - 0x2B ORN (A|~B) -> 4'h7
- All arithmetic is width-exact DW bits with no extension.

Decomposition:
- Shared package lu_pkg holds:
  - the LU_SEL codes (AND..ORN, 4-bit);
  - the FUNCT_* constants and OPCODE_RTYPE;
  - the state enum type;
  - the instruction field bit positions.
- Natural sub-module: lu_funct_decode, combinational funct/opcode -> {legal, sel[3:0]}.
- The FSM and datapath registers stay in lu_issue_ctrl.

Test Plan:
- Reset release, then AND: r1=32'hF0F0_1234, r2=32'h0FF0_FFFF, instr rs=1 rt=2 rd=3 funct=0x24 -> lu_sel=0 during EXEC; wr_en at cycle 3, wr_addr=3, wr_data=32'h00F0_1234; done pulse.
- NOR of r4=0, r5=32'h0000_FFFF into rd=6 -> wr_data=32'hFFFF_0000.
- Illegal funct 0x20 (or opcode 6'h08) -> illegal pulse 1 cycle after acceptance; no wr_en; instr_ready high again by cycle 2.
- rd=0 with XOR -> done pulse with wr_en=0.
- Back-to-back: instr_valid held high with two instructions -> second accepted exactly 4 cycles after the first; instr_ready low in READ/EXEC/WB.
- rst_n pulsed low during EXEC -> outputs return to 0 asynchronously; no wr_en/done; next instruction completes normally.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared constants and types for the logic-unit issue controller.
package lu_pkg;

  // Logic unit select codes
  localparam logic [3:0] LU_SEL_AND  = 4'h0;
  localparam logic [3:0] LU_SEL_OR   = 4'h1;
  localparam logic [3:0] LU_SEL_XOR  = 4'h2;
  localparam logic [3:0] LU_SEL_NOR  = 4'h3;
  localparam logic [3:0] LU_SEL_NAND = 4'h4;
  localparam logic [3:0] LU_SEL_XNOR = 4'h5;
  localparam logic [3:0] LU_SEL_ANDN = 4'h6;
  localparam logic [3:0] LU_SEL_ORN  = 4'h7;

  // R-type opcode and funct encodings
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] FUNCT_AND    = 6'h24;
  localparam logic [5:0] FUNCT_OR     = 6'h25;
  localparam logic [5:0] FUNCT_XOR    = 6'h26;
  localparam logic [5:0] FUNCT_NOR    = 6'h27;
  localparam logic [5:0] FUNCT_NAND   = 6'h28;
  localparam logic [5:0] FUNCT_XNOR   = 6'h29;
  localparam logic [5:0] FUNCT_ANDN   = 6'h2A;
  localparam logic [5:0] FUNCT_ORN    = 6'h2B;

  // Instruction field positions
  localparam int OP_MSB = 31, OP_LSB = 26;
  localparam int RS_MSB = 25, RS_LSB = 21;
  localparam int RT_MSB = 20, RT_LSB = 16;
  localparam int RD_MSB = 15, RD_LSB = 11;
  localparam int FN_MSB = 5,  FN_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_ERR
  } lu_state_e;

endpackage

// File: rtl/lu_funct_decode.sv
// Combinational opcode/funct decode to {legal, logic unit select}.
module lu_funct_decode
  import lu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       legal,
  output logic [3:0] sel
);

  // Only R-type opcodes with a mapped funct are legal; sel is 0 otherwise
  always_comb begin
    legal = 1'b0;
    sel   = LU_SEL_AND;
    if (opcode == OPCODE_RTYPE) begin
      legal = 1'b1;
      case (funct)
        FUNCT_AND:  sel = LU_SEL_AND;
        FUNCT_OR:   sel = LU_SEL_OR;
        FUNCT_XOR:  sel = LU_SEL_XOR;
        FUNCT_NOR:  sel = LU_SEL_NOR;
        FUNCT_NAND: sel = LU_SEL_NAND;
        FUNCT_XNOR: sel = LU_SEL_XNOR;
        FUNCT_ANDN: sel = LU_SEL_ANDN;
        FUNCT_ORN:  sel = LU_SEL_ORN;
        default:    legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/lu_issue_ctrl.sv
// Multi-cycle issue sequencer: decode, register read, logic unit execute, writeback.
module lu_issue_ctrl
  import lu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [DW-1:0] lu_a,
  output logic [DW-1:0] lu_b,
  output logic [3:0]    lu_sel,
  input  logic [DW-1:0] lu_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          done,
  output logic          illegal
);

  lu_state_e     state_q, state_d;
  logic          dec_legal;
  logic [3:0]    dec_sel;
  logic [3:0]    sel_q;
  logic [AW-1:0] rd_q;
  logic          accept;

  // shamt field is not used by logic ops
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  lu_funct_decode u_dec (
    .opcode (instr[OP_MSB:OP_LSB]),
    .funct  (instr[FN_MSB:FN_LSB]),
    .legal  (dec_legal),
    .sel    (dec_sel)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake; ready is masked while reset is held
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = rst_n;
        accept      = instr_valid;
        if (instr_valid) state_d = dec_legal ? ST_READ : ST_ERR;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers; pulses default low and are set on entry to WB/ERR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra1     <= '0;
      ra2     <= '0;
      rd_q    <= '0;
      sel_q   <= '0;
      lu_a    <= '0;
      lu_b    <= '0;
      lu_sel  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          ra1     <= AW'(instr[RS_MSB:RS_LSB]);
          ra2     <= AW'(instr[RT_MSB:RT_LSB]);
          rd_q    <= AW'(instr[RD_MSB:RD_LSB]);
          sel_q   <= dec_sel;
          illegal <= ~dec_legal;
        end
        ST_READ: begin
          lu_a   <= rd1;
          lu_b   <= rd2;
          lu_sel <= sel_q;
        end
        ST_EXEC: begin
          wr_data <= lu_out;
          wr_addr <= rd_q;
          wr_en   <= (rd_q != '0);  // r0 is hardwired, never written
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lu_issue_ctrl.sv
// Directed, table-driven bench for lu_issue_ctrl.
module tb_lu_issue_ctrl;

  logic        clk, rst_n;
  logic [31:0] instr;
  logic        instr_valid, instr_ready;
  logic [4:0]  ra1, ra2, wr_addr;
  logic [31:0] rd1, rd2, lu_a, lu_b, lu_out, wr_data;
  logic [3:0]  lu_sel;
  logic        wr_en, done, illegal;

  logic [31:0] rf [0:31];
  int n_cmp = 0;
  int n_bad = 0;

  lu_issue_ctrl #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_out(lu_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .illegal(illegal)
  );

  // Register file read ports and logic unit environment
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  always_comb begin
    lu_out = '0;
    case (lu_sel)
      4'h0: lu_out = lu_a & lu_b;
      4'h1: lu_out = lu_a | lu_b;
      4'h2: lu_out = lu_a ^ lu_b;
      4'h3: lu_out = ~(lu_a | lu_b);
      4'h4: lu_out = ~(lu_a & lu_b);
      4'h5: lu_out = ~(lu_a ^ lu_b);
      4'h6: lu_out = lu_a & ~lu_b;
      4'h7: lu_out = lu_a | ~lu_b;
      default: lu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b;
    logic        legal;
    logic [3:0]  sel;
    logic        wen;
    logic [31:0] wdata;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  // Offer one instruction at a negedge; returns once the accepting edge has passed
  task automatic issue(input vec_t v);
    rf[v.rs] = v.a;
    rf[v.rt] = v.b;
    instr       = mk(v.op, v.rs, v.rt, v.rd, v.fn);
    instr_valid = 1'b1;
    chk("ready_before_accept", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Full transaction with cycle-by-cycle checks
  task automatic run_vec(input vec_t v);
    issue(v);
    @(negedge clk);  // cycle 1
    chk("c1_ready", 32'(instr_ready), 32'd0);
    chk("c1_illegal", 32'(illegal), 32'(!v.legal));
    chk("c1_wr_en", 32'(wr_en), 32'd0);
    if (v.legal) begin
      chk("c1_ra1", 32'(ra1), 32'(v.rs));
      chk("c1_ra2", 32'(ra2), 32'(v.rt));
      @(negedge clk);  // cycle 2: EXEC
      chk("c2_ready", 32'(instr_ready), 32'd0);
      chk("c2_lu_sel", 32'(lu_sel), 32'(v.sel));
      chk("c2_lu_a", lu_a, v.a);
      chk("c2_lu_b", lu_b, v.b);
      chk("c2_done", 32'(done), 32'd0);
      @(negedge clk);  // cycle 3: WB
      chk("c3_ready", 32'(instr_ready), 32'd0);
      chk("c3_wr_en", 32'(wr_en), 32'(v.wen));
      chk("c3_done", 32'(done), 32'd1);
      chk("c3_wr_addr", 32'(wr_addr), 32'(v.rd));
      chk("c3_wr_data", wr_data, v.wdata);
      @(negedge clk);  // cycle 4: back in IDLE
      chk("c4_done", 32'(done), 32'd0);
      chk("c4_wr_en", 32'(wr_en), 32'd0);
      chk("c4_ready", 32'(instr_ready), 32'd1);
    end else begin
      chk("c1_done", 32'(done), 32'd0);
      @(negedge clk);  // cycle 2
      chk("c2_illegal", 32'(illegal), 32'd0);
      chk("c2_wr_en", 32'(wr_en), 32'd0);
      chk("c2_ready", 32'(instr_ready), 32'd1);
    end
  endtask

  initial begin
    vt[0] = '{6'h00, 6'h24, 5'd1,  5'd2,  5'd3,  32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 4'h0, 1'b1, 32'h00F0_1234};
    vt[1] = '{6'h00, 6'h27, 5'd4,  5'd5,  5'd6,  32'h0000_0000, 32'h0000_FFFF, 1'b1, 4'h3, 1'b1, 32'hFFFF_0000};
    vt[2] = '{6'h00, 6'h20, 5'd1,  5'd2,  5'd3,  32'h1,         32'h2,         1'b0, 4'h0, 1'b0, 32'h0};
    vt[3] = '{6'h08, 6'h24, 5'd1,  5'd2,  5'd3,  32'h1,         32'h2,         1'b0, 4'h0, 1'b0, 32'h0};
    vt[4] = '{6'h00, 6'h26, 5'd7,  5'd8,  5'd0,  32'hFFFF_0000, 32'h1234_5678, 1'b1, 4'h2, 1'b0, 32'hEDCB_5678};
    vt[5] = '{6'h00, 6'h25, 5'd9,  5'd10, 5'd11, 32'h0000_00FF, 32'h0F00_0000, 1'b1, 4'h1, 1'b1, 32'h0F00_00FF};
    vt[6] = '{6'h00, 6'h2B, 5'd12, 5'd13, 5'd14, 32'h0000_0000, 32'hFFFF_0000, 1'b1, 4'h7, 1'b1, 32'h0000_FFFF};
    vt[7] = '{6'h00, 6'h2A, 5'd15, 5'd16, 5'd17, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b1, 4'h6, 1'b1, 32'hF0F0_F0F0};
    vt[8] = '{6'h00, 6'h28, 5'd18, 5'd19, 5'd20, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b1, 4'h4, 1'b1, 32'h0FFF_0FFF};
    vt[9] = '{6'h00, 6'h29, 5'd21, 5'd22, 5'd31, 32'hAAAA_AAAA, 32'hAAAA_5555, 1'b1, 4'h5, 1'b1, 32'hFFFF_0000};

    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    instr = '0;
    instr_valid = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_ra1", 32'(ra1), 32'd0);
    chk("rst_lu_a", lu_a, 32'd0);
    chk("rst_lu_sel", 32'(lu_sel), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_pulses", {29'd0, wr_en, done, illegal}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    // Table-driven transactions
    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Back-to-back: valid held high, second instruction accepted 4 cycles after first
    begin
      int acc_cyc;
      acc_cyc = -1;
      rf[1] = 32'hF0F0_1234; rf[2] = 32'h0FF0_FFFF;
      rf[9] = 32'h0000_00FF; rf[10] = 32'h0F00_0000;
      instr = mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h24);
      instr_valid = 1'b1;
      chk("b2b_ready0", 32'(instr_ready), 32'd1);
      @(posedge clk);
      #1 instr = mk(6'h00, 5'd9, 5'd10, 5'd11, 6'h25);
      for (int c = 1; c <= 6 && acc_cyc < 0; c++) begin
        @(negedge clk);
        if (instr_ready) acc_cyc = c;
        else if (c == 3) begin
          chk("b2b_first_wr_data", wr_data, 32'h00F0_1234);
          chk("b2b_first_done", 32'(done), 32'd1);
        end
      end
      chk("b2b_accept_cycle", 32'(acc_cyc), 32'd4);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b_second_wr_en", 32'(wr_en), 32'd1);
      chk("b2b_second_wr_addr", 32'(wr_addr), 32'd11);
      chk("b2b_second_wr_data", wr_data, 32'h0F00_00FF);
      @(negedge clk);
    end

    // Reset during EXEC aborts without writeback
    begin
      int seen;
      seen = 0;
      issue(vt[1]);
      @(negedge clk);
      @(negedge clk);
      chk("abort_exec_sel", 32'(lu_sel), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("abort_lu_a", lu_a, 32'd0);
      chk("abort_lu_b", lu_b, 32'd0);
      chk("abort_lu_sel", 32'(lu_sel), 32'd0);
      chk("abort_ra2", 32'(ra2), 32'd0);
      chk("abort_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (wr_en || done || illegal) seen++;
      end
      chk("abort_no_pulses", 32'(seen), 32'd0);
      run_vec(vt[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
